// File: rtl/mu0_wait_mem.sv
// MU0 bus memory with a fixed wait-state count and a one-cycle rdy/err pulse.
// Write data and the address are captured on accept. Read data drives the bus only in ACK.
module mu0_wait_mem #(
  parameter int    AW          = 12,
  parameter int    DW          = 16,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memrq,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          rdy,
  output logic          err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          rnw_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rd_q;
  logic          err_q;
  logic [DW-1:0] mem [DEPTH];

  logic          idle;
  logic          acc_rnw;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [IW-1:0] idx;
  logic          in_rng;
  logic          commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (memrq) begin
          state_d = (WAIT_STATES == 0) ? ACK : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == 8'(WAIT_STATES)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the accept edge is also the commit edge,
  // so the access is taken straight from the bus in IDLE.
  assign idle      = (state_q == IDLE);
  assign acc_rnw   = idle ? rnw  : rnw_q;
  assign acc_addr  = idle ? addr : addr_q;
  assign acc_wdata = idle ? data : wdata_q;
  assign idx       = acc_addr[IW-1:0];
  assign in_rng    = 32'(acc_addr) < DEPTH;
  assign commit    = (state_d == ACK) && !reset;

  always_ff @(posedge clk) begin
    if (commit && !acc_rnw && in_rng) mem[idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && memrq) begin
        addr_q  <= addr;
        rnw_q   <= rnw;
        wdata_q <= data;
      end
      if (commit) begin
        err_q <= !in_rng;
        rd_q  <= (acc_rnw && in_rng) ? mem[idx] : '0;
      end
    end
  end

  assign rdy  = (state_q == ACK);
  assign err  = rdy && err_q;
  assign data = (rdy && rnw_q) ? rd_q : 'z;

endmodule

// File: tb/tb_mu0_wait_mem.sv
// Random and directed accesses on two memory instances (0 and 3 wait states)
// checked against an array model of contents, latency and range errors.
module tb_mu0_wait_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memrq [2];
  logic        rnw   [2];
  logic        den   [2];
  logic [11:0] addr  [2];
  logic [15:0] dout  [2];
  wire  [15:0] data0, data1;
  wire         rdy0, rdy1, err0, err1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mm    [2][4096];
  bit          known [2][4096];
  logic [15:0] zz = 'z;

  always #5 clk = ~clk;

  assign data0 = den[0] ? dout[0] : 'z;
  assign data1 = den[1] ? dout[1] : 'z;

  mu0_wait_mem #(.AW(12), .DW(16), .DEPTH(4096), .WAIT_STATES(0)) u_m0 (
    .clk(clk), .reset(reset), .memrq(memrq[0]), .rnw(rnw[0]),
    .addr(addr[0]), .data(data0), .rdy(rdy0), .err(err0));

  mu0_wait_mem #(.AW(12), .DW(16), .DEPTH(256), .WAIT_STATES(3)) u_m1 (
    .clk(clk), .reset(reset), .memrq(memrq[1]), .rnw(rnw[1]),
    .addr(addr[1]), .data(data1), .rdy(rdy1), .err(err1));

  function automatic int ws(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int dep(int k);
    return (k == 0) ? 4096 : 256;
  endfunction

  function automatic logic g_rdy(int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic g_err(int k);
    return (k == 0) ? err0 : err1;
  endfunction

  function automatic logic [15:0] g_bus(int k);
    return (k == 0) ? data0 : data1;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(int k, bit r, logic [11:0] a, logic [15:0] wd, bit tog);
    bit got = 0;
    bit oor = (int'(a) >= dep(k));
    @(negedge clk);
    memrq[k] = 1'b1;
    rnw[k]   = r;
    addr[k]  = a;
    dout[k]  = wd;
    den[k]   = !r;
    for (int c = 1; c <= ws(k) + 6 && !got; c++) begin
      @(negedge clk);
      if (g_rdy(k)) begin
        got = 1;
        check("latency", c, ws(k) + 1);
        check("err", {31'd0, g_err(k)}, {31'd0, oor});
        if (r && oor) check("rd_oor", {16'd0, g_bus(k)}, 32'd0);
        else if (r && known[k][a]) check("rd", {16'd0, g_bus(k)}, {16'd0, mm[k][a]});
        memrq[k] = 1'b0;
        den[k]   = 1'b0;
      end else begin
        if (r) check("busz_wait", {16'd0, g_bus(k)}, {16'd0, zz});
        if (tog) begin
          addr[k] = 12'($urandom);
          dout[k] = 16'($urandom);
          rnw[k]  = 1'($urandom);
        end
      end
    end
    if (!got) begin
      check("rdy_timeout", 32'd0, 32'd1);
      memrq[k] = 1'b0;
      den[k]   = 1'b0;
    end
    @(negedge clk);
    check("rdy_drop", {31'd0, g_rdy(k)}, 32'd0);
    check("busz_after", {16'd0, g_bus(k)}, {16'd0, zz});
    if (!r && !oor) begin
      mm[k][a]    = wd;
      known[k][a] = 1'b1;
    end
  endtask

  function automatic logic [11:0] pick(int k);
    logic [3:0] r = 4'($urandom);
    if (k == 0) return 12'h060 + 12'(r);
    case ($urandom_range(0, 3))
      0:       return 12'h000 + 12'(r);
      1:       return 12'h0F0 + 12'(r);
      2:       return 12'h100 + 12'(r);
      default: return 12'h1F0 + 12'(r);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      memrq[k] = 1'b0;
      rnw[k]   = 1'b1;
      den[k]   = 1'b0;
      addr[k]  = '0;
      dout[k]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_rdy0", {31'd0, rdy0}, 32'd0);
    check("rst_rdy1", {31'd0, rdy1}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_err1", {31'd0, err1}, 32'd0);
    check("rst_bus0", {16'd0, data0}, {16'd0, zz});
    check("rst_bus1", {16'd0, data1}, {16'd0, zz});
    reset = 1'b0;

    access(0, 0, 12'h064, 16'h4444, 0);
    access(0, 1, 12'h064, 16'h0000, 0);
    access(1, 0, 12'h065, 16'hBEEF, 0);
    access(1, 1, 12'h065, 16'h0000, 1);
    access(1, 0, 12'h0FF, 16'h1234, 0);
    access(1, 1, 12'h100, 16'h0000, 0);
    access(1, 0, 12'h1FF, 16'hDEAD, 1);
    access(1, 1, 12'h0FF, 16'h0000, 0);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        access(k, 0, pick(k), 16'($urandom), 1'($urandom));
      end

    access(1, 0, 12'h010, 16'hA5A5, 0);
    @(negedge clk);
    memrq[1] = 1'b1;
    rnw[1]   = 1'b0;
    addr[1]  = 12'h010;
    dout[1]  = 16'h5A5A;
    den[1]   = 1'b1;
    @(negedge clk);
    check("wait_no_rdy", {31'd0, rdy1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    memrq[1] = 1'b0;
    den[1]   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("abort_no_rdy", {31'd0, rdy1}, 32'd0);
      @(negedge clk);
    end
    access(1, 1, 12'h010, 16'h0000, 0);

    for (int i = 0; i < 120; i++) begin
      int k = int'($urandom_range(0, 1));
      access(k, 1'($urandom), pick(k), 16'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
